// File: rtl/two_output_demux_pkg.sv
// Shared constants and types for the buffered 1-to-2 demultiplexer.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package two_output_demux_pkg;

    // Default data width matches the ALU result bus.
    localparam int DEMUX_WIDTH = 16;
    // Default entries per output queue (power of two, >= 2).
    localparam int DEMUX_DEPTH = 2;

    // Destination encoding carried on SelectorBit.
    typedef enum logic {
        SEL_ZERO = 1'b0,
        SEL_ONE  = 1'b1
    } demux_sel_e;

endpackage

// File: rtl/two_output_demux_queue.sv
// Generic FIFO used for each demux output: push/pop, full/valid flags, head data.
// Latency: 1 cycle push-to-valid (no bypass); head driven straight from storage.
// Backpressure: full blocks push (even with a same-cycle pop); pop when vld && pop_rdy.
//
// Ports: clk, rst_n (async active-low); push/push_dat (push must already be
// qualified against full); pop_rdy from the consumer; full, vld, dat outputs.
module demux_queue
    import two_output_demux_pkg::*;
#(
    parameter int WIDTH = DEMUX_WIDTH,
    parameter int DEPTH = DEMUX_DEPTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop_rdy,
    output logic             full,
    output logic             vld,
    output logic [WIDTH-1:0] dat
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] storage [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             pop;

    assign full = (count == CW'(DEPTH));
    assign vld  = (count != '0);
    assign pop  = vld && pop_rdy;
    assign dat  = storage[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            // Simultaneous push and pop leaves count unchanged.
            if (push && !pop)      count <= count + 1'b1;
            else if (!push && pop) count <= count - 1'b1;
        end
    end

    // Storage is cleared on reset so an empty queue presents zero at its head.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) storage[i] <= '0;
        end else if (push) begin
            storage[wr_ptr] <= push_dat;
        end
    end

endmodule

// File: rtl/two_output_demux.sv
// Buffered 1-to-2 demux: steers each input word by SelectorBit into queue Zero or One.
// Latency: 1 cycle from accepted input to output valid; 1 word/cycle total input rate.
// Backpressure: InReady reflects only the selected queue's full flag; each output drains independently.
//
// Ports: CLK, Reset_n (async active-low); In/InValid/SelectorBit/InReady input
// handshake; Zero/ZeroValid/ZeroReady and One/OneValid/OneReady output handshakes.
module two_output_demux
    import two_output_demux_pkg::*;
#(
    parameter int WIDTH = DEMUX_WIDTH,
    parameter int DEPTH = DEMUX_DEPTH
) (
    input  logic             CLK,
    input  logic             Reset_n,
    input  logic [WIDTH-1:0] In,
    input  logic             InValid,
    input  logic             SelectorBit,
    output logic             InReady,
    output logic [WIDTH-1:0] Zero,
    output logic             ZeroValid,
    input  logic             ZeroReady,
    output logic [WIDTH-1:0] One,
    output logic             OneValid,
    input  logic             OneReady
);

    logic       zero_full;
    logic       one_full;
    logic       zero_push;
    logic       one_push;
    demux_sel_e sel;

    assign sel = demux_sel_e'(SelectorBit);

    // Ready is derived from registered full flags only, so there is no
    // combinational path from either output ready back to InReady.
    assign InReady   = (sel == SEL_ONE) ? !one_full : !zero_full;
    assign zero_push = InValid && InReady && (sel == SEL_ZERO);
    assign one_push  = InValid && InReady && (sel == SEL_ONE);

    demux_queue #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_zero_q (
        .clk      (CLK),
        .rst_n    (Reset_n),
        .push     (zero_push),
        .push_dat (In),
        .pop_rdy  (ZeroReady),
        .full     (zero_full),
        .vld      (ZeroValid),
        .dat      (Zero)
    );

    demux_queue #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_one_q (
        .clk      (CLK),
        .rst_n    (Reset_n),
        .push     (one_push),
        .push_dat (In),
        .pop_rdy  (OneReady),
        .full     (one_full),
        .vld      (OneValid),
        .dat      (One)
    );

endmodule

// File: tb/tb_two_output_demux.sv
// Self-checking bench for two_output_demux against a queue-based reference model.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_two_output_demux;

    localparam int W = 16;
    localparam int D = 2;

    logic         CLK;
    logic         Reset_n;
    logic [W-1:0] In;
    logic         InValid;
    logic         SelectorBit;
    logic         InReady;
    logic [W-1:0] Zero;
    logic         ZeroValid;
    logic         ZeroReady;
    logic [W-1:0] One;
    logic         OneValid;
    logic         OneReady;

    two_output_demux #(.WIDTH(W), .DEPTH(D)) dut (
        .CLK         (CLK),
        .Reset_n     (Reset_n),
        .In          (In),
        .InValid     (InValid),
        .SelectorBit (SelectorBit),
        .InReady     (InReady),
        .Zero        (Zero),
        .ZeroValid   (ZeroValid),
        .ZeroReady   (ZeroReady),
        .One         (One),
        .OneValid    (OneValid),
        .OneReady    (OneReady)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Reference model: each output is a bounded FIFO of capacity D.
    logic [W-1:0] q0[$];
    logic [W-1:0] q1[$];
    // Words actually observed leaving the DUT, for order checks.
    logic [W-1:0] zlog[$];
    logic [W-1:0] olog[$];

    int checks = 0;
    int passes = 0;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) begin
            passes++;
        end else begin
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, check outputs at the falling edge,
    // log handshakes, advance the model, then return just after the rising edge.
    task automatic step(input logic iv, input logic sel, input logic [W-1:0] d,
                        input logic zr, input logic orr);
        logic exp_ir;
        logic acc;
        InValid     = iv;
        SelectorBit = sel;
        In          = d;
        ZeroReady   = zr;
        OneReady    = orr;
        @(negedge CLK);
        exp_ir = sel ? (q1.size() < D) : (q0.size() < D);
        chk("in_ready", {15'd0, InReady}, {15'd0, exp_ir});
        chk("zero_valid", {15'd0, ZeroValid}, {15'd0, q0.size() > 0});
        chk("one_valid", {15'd0, OneValid}, {15'd0, q1.size() > 0});
        if (q0.size() > 0) chk("zero_head", Zero, q0[0]);
        if (q1.size() > 0) chk("one_head", One, q1[0]);
        if (ZeroValid && zr) zlog.push_back(Zero);
        if (OneValid && orr) olog.push_back(One);
        // Acceptance is decided on pre-edge occupancy, so a full queue
        // cannot be pushed even while it pops.
        acc = iv && exp_ir;
        if (q0.size() > 0 && zr) void'(q0.pop_front());
        if (q1.size() > 0 && orr) void'(q1.pop_front());
        if (acc && !sel) q0.push_back(d);
        if (acc && sel)  q1.push_back(d);
        @(posedge CLK);
        #1;
    endtask

    initial begin
        int idx;
        int budget;
        logic [W-1:0] w;
        Reset_n     = 1'b0;
        In          = '0;
        InValid     = 1'b0;
        SelectorBit = 1'b0;
        ZeroReady   = 1'b0;
        OneReady    = 1'b0;
        #2;
        chk("rst_zero_valid", {15'd0, ZeroValid}, 16'd0);
        chk("rst_one_valid", {15'd0, OneValid}, 16'd0);
        chk("rst_in_ready", {15'd0, InReady}, 16'd1);
        chk("rst_zero_dat", Zero, 16'h0000);
        chk("rst_one_dat", One, 16'h0000);
        @(posedge CLK);
        #1;
        Reset_n = 1'b1;

        // Steering and order.
        zlog.delete(); olog.delete();
        step(1, 0, 16'h1111, 1, 1);
        step(1, 1, 16'h2222, 1, 1);
        step(1, 0, 16'h3333, 1, 1);
        step(0, 0, 16'h0000, 1, 1);
        step(0, 0, 16'h0000, 1, 1);
        chk("steer_zero_count", 16'(zlog.size()), 16'd2);
        chk("steer_one_count", 16'(olog.size()), 16'd1);
        if (zlog.size() == 2) begin
            chk("steer_zero_0", zlog[0], 16'h1111);
            chk("steer_zero_1", zlog[1], 16'h3333);
        end
        if (olog.size() == 1) chk("steer_one_0", olog[0], 16'h2222);

        // Full queue on the blocked side, other side still accepts.
        zlog.delete(); olog.delete();
        step(1, 0, 16'hA001, 0, 1);
        step(1, 0, 16'hA002, 0, 1);
        step(1, 0, 16'hA003, 0, 1);
        chk("full_blocks", {15'd0, InReady}, 16'd0);
        step(1, 1, 16'hB001, 0, 1);
        // Full with simultaneous pop: refused this cycle, taken next.
        step(1, 0, 16'hA003, 1, 1);
        chk("full_pop_refused", 16'(q0.size()), 16'd1);
        step(1, 0, 16'hA003, 1, 1);
        for (int i = 0; i < 4; i++) step(0, 0, 16'h0000, 1, 1);
        chk("full_zero_count", 16'(zlog.size()), 16'd3);
        if (zlog.size() == 3) begin
            chk("full_zero_0", zlog[0], 16'hA001);
            chk("full_zero_1", zlog[1], 16'hA002);
            chk("full_zero_2", zlog[2], 16'hA003);
        end
        chk("full_one_b001", (olog.size() == 1) ? olog[0] : 16'hXXXX, 16'hB001);

        // Wrap-around through queue 1 with OneReady toggling.
        zlog.delete(); olog.delete();
        idx = 1;
        budget = 0;
        while (olog.size() < 5 && budget < 60) begin
            if (idx <= 5) begin
                w = 16'(idx);
                if (q1.size() < D) idx++;
                step(1, 1, w, 1, budget[0]);
            end else begin
                step(0, 1, 16'h0000, 1, budget[0]);
            end
            budget++;
        end
        chk("wrap_count", 16'(olog.size()), 16'd5);
        for (int i = 0; i < 5; i++)
            if (i < olog.size()) chk("wrap_word", olog[i], 16'(i + 1));

        // Idle input with words held in both queues.
        step(1, 0, 16'h5A5A, 0, 0);
        step(1, 1, 16'hA5A5, 0, 0);
        for (int i = 0; i < 4; i++) step(0, i[0], 16'hFFFF, 0, 0);
        chk("idle_zero_head", Zero, 16'h5A5A);
        chk("idle_one_head", One, 16'hA5A5);

        // Reset mid-stream: both queues hold words.
        step(1, 0, 16'hC001, 0, 0);
        Reset_n = 1'b0;
        #1;
        chk("midrst_zero_valid", {15'd0, ZeroValid}, 16'd0);
        chk("midrst_one_valid", {15'd0, OneValid}, 16'd0);
        SelectorBit = 1'b0;
        #1;
        chk("midrst_in_ready0", {15'd0, InReady}, 16'd1);
        SelectorBit = 1'b1;
        #1;
        chk("midrst_in_ready1", {15'd0, InReady}, 16'd1);
        chk("midrst_zero_dat", Zero, 16'h0000);
        q0.delete(); q1.delete();
        @(posedge CLK);
        #1;
        Reset_n = 1'b1;
        zlog.delete(); olog.delete();
        for (int i = 0; i < 3; i++) step(0, 0, 16'h0000, 1, 1);
        chk("postrst_no_stale", 16'(zlog.size() + olog.size()), 16'd0);

        // Randomised traffic against the model.
        zlog.delete(); olog.delete();
        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), 16'($urandom),
                 $urandom_range(0, 2) != 0, $urandom_range(0, 2) != 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
